// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer: synchroniser, glitch-rejecting level tracker and
// press/release pulses per channel. Define BTN_AUTOREPEAT_EN to add held-key repeat pulses.
module btn_debounce_multi #(
   parameter int unsigned N_CH            = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter bit          ACTIVE_LOW      = 1'b0,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release,
   output logic [N_CH-1:0] btn_repeat,
   output logic            any_press
);

   localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
   logic [N_CH-1:0]                  sync_out;
   logic [N_CH-1:0][CntW-1:0]        cnt_q, cnt_d;
   logic [N_CH-1:0]                  level_q, level_d;
   logic [N_CH-1:0]                  press_q, press_d;
   logic [N_CH-1:0]                  release_q, release_d;
   logic                             any_press_q, any_press_d;

   // Inversion ahead of the synchroniser so reset value 0 always means "released".
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], btn_raw ^ {N_CH{ACTIVE_LOW}}};
      sync_out = sync_q[SYNC_STAGES-1];
   end

   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         cnt_d[i]     = '0;
         level_d[i]   = level_q[i];
         press_d[i]   = 1'b0;
         release_d[i] = 1'b0;
         if (sync_out[i] != level_q[i]) begin
            if (cnt_q[i] == CntLast) begin
               level_d[i]   = ~level_q[i];
               press_d[i]   = ~level_q[i];
               release_d[i] = level_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntW'(1);
            end
         end
      end
      any_press_d = |press_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         level_q     <= '0;
         press_q     <= '0;
         release_q   <= '0;
         any_press_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         any_press_q <= any_press_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign any_press   = any_press_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [31:0] RepLast   = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] RepReload = 32'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [N_CH-1:0][31:0] rep_cnt_q, rep_cnt_d;
   logic [N_CH-1:0]       repeat_q, repeat_d;

   // Counting only while the level stays high suppresses a repeat on the release edge.
   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         rep_cnt_d[i] = '0;
         repeat_d[i]  = 1'b0;
         if (level_q[i] && level_d[i]) begin
            if (rep_cnt_q[i] == RepLast) begin
               repeat_d[i]  = 1'b1;
               rep_cnt_d[i] = RepReload;
            end else begin
               rep_cnt_d[i] = rep_cnt_q[i] + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_q <= '0;
         repeat_q  <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         repeat_q  <= repeat_d;
      end
   end

   assign btn_repeat = repeat_q;
`else
   assign btn_repeat = '0;
`endif

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Per channel: synchronises a raw push-button input, rejects bounce, tracks a debounced level, and emits one-cycle press and release pulses.
- Sits between board button pins and the CPU / IO-register front end; an optional auto-repeat mode generates held-key repeat pulses.

Parameters:
- N_CH, 4, number of independent button channels (1..32).
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a level change (>=2).
- SYNC_STAGES, 2, flip-flops in the input synchroniser (>=2).
- ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed; inverted before the synchroniser.
- REPEAT_DELAY, 50000000, cycles from press pulse to first repeat pulse (auto-repeat only).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (auto-repeat only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- btn_raw  in  N_CH  raw asynchronous button pins.
- btn_level  out  N_CH  debounced level, 1 = pressed.
- btn_press  out  N_CH  one-cycle pulse per accepted press.
- btn_release  out  N_CH  one-cycle pulse per accepted release.
- btn_repeat  out  N_CH  one-cycle auto-repeat pulses; constant 0 when feature compiled out.
- any_press  out  1  OR of btn_press, registered together with it (same cycle).

Behaviour:
- Reset: synchroniser flops, btn_level, btn_press, btn_release, btn_repeat, any_press, debounce counters and repeat counters all 0.
  - Synchroniser resets to the "released" level, after ACTIVE_LOW inversion.
- Channels are fully independent; simultaneous events on several channels are each reported in the same cycle.
- Input path per channel:
  - s = btn_raw[i] XOR ACTIVE_LOW.
  - s passes through SYNC_STAGES flops to give sync[i].
- Debounce counter:
  - Width $clog2(DEBOUNCE_CYCLES+1).
  - Each edge with sync[i] != btn_level[i]: counter increments.
  - Each edge with sync[i] == btn_level[i]: counter clears to 0 (glitch rejection; any bounce restarts the count).
  - When counter reaches DEBOUNCE_CYCLES: on that edge btn_level toggles and the counter clears.
    - Rising toggle sets btn_press=1.
    - Falling toggle sets btn_release=1.
  - Pulses are high for exactly one cycle.
- Latency:
  - A clean raw step makes its pulse visible after the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge.
  - Edges are counted from the first edge that samples the new raw value.
  - btn_level changes on the same edge as the pulse.
- Pulse exclusivity: btn_press and btn_release are never high together on one channel.
- Minimum pulse spacing per channel is DEBOUNCE_CYCLES cycles.
- Counter cannot overflow: it clears at DEBOUNCE_CYCLES.
- Reset mid-operation: all state is lost.
  - A button held through reset deassertion is reported as a fresh press after the full latency.
  - No release pulse is generated by reset.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined:
  - Per-channel 32-bit repeat counter, cleared on btn_press and whenever btn_level=0.
  - While btn_level=1 it increments each cycle.
  - At REPEAT_DELAY: btn_repeat pulses one cycle and the counter reloads so the next pulse follows REPEAT_PERIOD cycles later; this repeats every REPEAT_PERIOD while held.
  - On the release edge (btn_level falls) no further repeat pulse is issued, including in that same cycle.
  - btn_repeat never coincides with btn_press.
- Not defined: repeat logic absent, btn_repeat tied to 0, all other behaviour identical.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, N_CH=4, ACTIVE_LOW=0 unless noted):
- Clean press on ch0:
  - Stimulus: btn_raw[0] 0->1, held 40 cycles.
  - Required: btn_press[0] and any_press high exactly 1 cycle, after the 10th edge; btn_level[0]=1; no other channel active.
- Bounce rejection:
  - Stimulus: btn_raw[1] toggles high 5 cycles / low 2 / high 5 / low.
  - Required: no pulses and btn_level[1]=0 throughout; then hold high 20 cycles -> single press pulse.
- Release with simultaneous channels:
  - Stimulus: ch2 and ch3 pressed in the same cycle; later both released in the same cycle.
  - Required: press[2]/press[3] pulse on the same edge; release[2]/release[3] pulse on the same edge, 10 edges after release.
- ACTIVE_LOW=1:
  - Stimulus: btn_raw=4'hF idle, then ch0 driven 0.
  - Required: btn_level=0 while idle; press[0] after 10 edges.
- Reset mid-hold:
  - Stimulus: ch0 pressed and debounced, rst_n pulsed low 3 cycles while still held.
  - Required: all outputs 0 during reset, no release pulse, press[0] re-issued 10 edges after reset deassert.
- BTN_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5:
  - Stimulus: hold ch1 60 cycles.
  - Required: btn_repeat[1] first 20 cycles after the press pulse, then every 5 cycles; none after btn_level[1] falls.
